// File: rtl/adder_measure_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : adder_measure_sequencer
//  Brief    : Sequences one ring-oscillator timing run on the instrumented
//             adder: load, settle, timed window, drain, report edge count.
//  Revision : 1.0  initial release
// ============================================================================
module adder_measure_sequencer #(
    parameter int WIDTH         = 32,
    parameter int SEL_W         = 5,
    parameter int WIN_W         = 16,
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int CNT_W         = 32
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             active,
    input  logic             start,
    input  logic [WIN_W-1:0] window_cycles,
    input  logic [WIDTH-1:0] a_operand,
    input  logic [WIDTH-1:0] b_operand,
    input  logic [SEL_W-1:0] ring_bit_sel,
    input  logic [SEL_W-1:0] out_bit_sel,
    input  logic             chain_in,
    output logic [WIDTH-1:0] a_input,
    output logic [WIDTH-1:0] b_input,
    output logic [WIDTH-1:0] a_input_ring_bit_b,
    output logic [WIDTH-1:0] s_output_bit_b,
    output logic             ring_en,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_LOAD   = 3'd1;
    localparam logic [2:0] c_SETTLE = 3'd2;
    localparam logic [2:0] c_RUN    = 3'd3;
    localparam logic [2:0] c_DRAIN  = 3'd4;
    localparam logic [2:0] c_DONE   = 3'd5;

    localparam int               c_TMR_W     = (WIN_W > 8) ? WIN_W : 8;
    localparam logic [c_TMR_W-1:0] c_SETTLE_M1 = c_TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_DRAIN_M1  = c_TMR_W'(SYNC_STAGES);
    localparam logic [WIDTH-1:0] c_ONE       = WIDTH'(1);

    logic [2:0]             r_state;
    logic [2:0]             w_state_nxt;
    logic [c_TMR_W-1:0]     r_tmr;
    logic [c_TMR_W-1:0]     w_tmr_nxt;
    logic [c_TMR_W-1:0]     w_win_m1;
    logic                   w_abort;
    logic                   w_start_ok;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_prev;
    logic                   w_edge;
    logic                   w_count_en;
    logic                   r_ring_en;
    logic                   r_done;
    logic                   r_aborted;
    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic [WIDTH-1:0]       r_ring_mask;
    logic [WIDTH-1:0]       r_out_mask;
    logic [CNT_W-1:0]       r_count;
    logic                   r_overflow;

    assign w_win_m1   = c_TMR_W'(window_cycles) - c_TMR_W'(1);
    assign w_start_ok = (r_state == c_IDLE) && start && active;
    assign w_edge     = r_sync[SYNC_STAGES-1] & ~r_sync_prev;
    // Edges still in the synchronizer when the window closes are caught in DRAIN.
    assign w_count_en = w_edge && ((r_state == c_RUN) || (r_state == c_DRAIN));

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        w_abort     = 1'b0;
        if ((r_state != c_IDLE) && !active) begin
            w_state_nxt = c_IDLE;
            w_abort     = 1'b1;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start && active) w_state_nxt = c_LOAD;
                end
                c_LOAD: begin
                    w_state_nxt = c_SETTLE;
                    w_tmr_nxt   = c_SETTLE_M1;
                end
                c_SETTLE: begin
                    if (r_tmr == '0) begin
                        if (window_cycles == '0) begin
                            w_state_nxt = c_DRAIN;
                            w_tmr_nxt   = c_DRAIN_M1;
                        end else begin
                            w_state_nxt = c_RUN;
                            w_tmr_nxt   = w_win_m1;
                        end
                    end else begin
                        w_tmr_nxt = r_tmr - c_TMR_W'(1);
                    end
                end
                c_RUN: begin
                    if (r_tmr == '0) begin
                        w_state_nxt = c_DRAIN;
                        w_tmr_nxt   = c_DRAIN_M1;
                    end else begin
                        w_tmr_nxt = r_tmr - c_TMR_W'(1);
                    end
                end
                c_DRAIN: begin
                    if (r_tmr == '0) w_state_nxt = c_DONE;
                    else             w_tmr_nxt   = r_tmr - c_TMR_W'(1);
                end
                c_DONE:  w_state_nxt = c_IDLE;
                default: w_state_nxt = c_IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= c_IDLE;
            r_tmr       <= '0;
            r_ring_en   <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_sync      <= '0;
            r_sync_prev <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_ring_mask <= '0;
            r_out_mask  <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tmr       <= w_tmr_nxt;
            // Flopped from next-state so the oscillator enable is glitch-free.
            r_ring_en   <= (w_state_nxt == c_RUN);
            r_done      <= (w_state_nxt == c_DONE);
            r_aborted   <= w_abort;
            r_sync      <= {r_sync[SYNC_STAGES-2:0], chain_in};
            r_sync_prev <= r_sync[SYNC_STAGES-1];
            if (r_state == c_LOAD) begin
                r_a         <= a_operand;
                r_b         <= b_operand;
                r_ring_mask <= c_ONE << ring_bit_sel;
                r_out_mask  <= c_ONE << out_bit_sel;
            end
            if (w_start_ok) begin
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else if (w_count_en) begin
                if (&r_count) r_overflow <= 1'b1;
                else          r_count    <= r_count + CNT_W'(1);
            end
        end
    end

    assign a_input            = r_a;
    assign b_input            = r_b;
    assign a_input_ring_bit_b = r_ring_mask;
    assign s_output_bit_b     = r_out_mask;
    assign ring_en            = r_ring_en;
    assign busy               = (r_state != c_IDLE);
    assign done               = r_done;
    assign aborted            = r_aborted;
    assign count              = r_count;
    assign overflow           = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_adder_measure_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder_measure_sequencer
//  Brief    : Self-checking bench; a default instance and a 4-bit-counter
//             instance share stimulus, checked against a cycle-offset model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adder_measure_sequencer;

    localparam int S  = 4;
    localparam int SS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        active;
    logic        start;
    logic [15:0] window_cycles;
    logic [31:0] a_operand;
    logic [31:0] b_operand;
    logic [4:0]  ring_bit_sel;
    logic [4:0]  out_bit_sel;
    logic        chain_in;

    logic [31:0] a_input, b_input, ring_mask, out_mask;
    logic        ring_en, busy, done, aborted, overflow;
    logic [31:0] count;
    logic [31:0] a_input_s, b_input_s, ring_mask_s, out_mask_s;
    logic        ring_en_s, busy_s, done_s, aborted_s, overflow_s;
    logic [3:0]  count_s;

    always #5 clk = ~clk;

    adder_measure_sequencer dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .active(active), .start(start),
        .window_cycles(window_cycles), .a_operand(a_operand), .b_operand(b_operand),
        .ring_bit_sel(ring_bit_sel), .out_bit_sel(out_bit_sel), .chain_in(chain_in),
        .a_input(a_input), .b_input(b_input), .a_input_ring_bit_b(ring_mask),
        .s_output_bit_b(out_mask), .ring_en(ring_en), .busy(busy), .done(done),
        .aborted(aborted), .count(count), .overflow(overflow)
    );

    adder_measure_sequencer #(.CNT_W(4)) dut_sat (
        .wb_clk_i(clk), .wb_rst_i(rst), .active(active), .start(start),
        .window_cycles(window_cycles), .a_operand(a_operand), .b_operand(b_operand),
        .ring_bit_sel(ring_bit_sel), .out_bit_sel(out_bit_sel), .chain_in(chain_in),
        .a_input(a_input_s), .b_input(b_input_s), .a_input_ring_bit_b(ring_mask_s),
        .s_output_bit_b(out_mask_s), .ring_en(ring_en_s), .busy(busy_s), .done(done_s),
        .aborted(aborted_s), .count(count_s), .overflow(overflow_s)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " a_input"},   a_input,   0);
        chk({tag, " b_input"},   b_input,   0);
        chk({tag, " ring_mask"}, ring_mask, 0);
        chk({tag, " out_mask"},  out_mask,  0);
        chk({tag, " ring_en"},   ring_en,   0);
        chk({tag, " busy"},      busy,      0);
        chk({tag, " done"},      done,      0);
        chk({tag, " aborted"},   aborted,   0);
        chk({tag, " count"},     count,     0);
        chk({tag, " overflow"},  overflow,  0);
        chk({tag, " count_s"},   count_s,   0);
        chk({tag, " busy_s"},    busy_s,    0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Results of the last do_run, as cycle offsets from the start cycle.
    int res_done_at, res_abort_at, res_ren_cnt, res_ren_first, res_model_n;
    logic res_busy0;

    // Offset 0 is the cycle in which start is presented. half>0 emulates the
    // ring (toggle every 'half' enabled cycles); rnd toggles chain_in at random.
    task automatic do_run(input int half, input bit rnd, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rs, input logic [4:0] os, input logic [15:0] win,
                          input int abort_at, input bit hold_start);
        int   ring_r;
        int   limit;
        logic lvl_prev;
        res_done_at = -1; res_abort_at = -1; res_ren_cnt = 0; res_ren_first = -1;
        res_model_n = 0; res_busy0 = 1'b0; ring_r = 0;
        limit = 5 + S + int'(win) + 10;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (c == 0) res_busy0 = busy;
            else begin
                if (done)    res_done_at  = c;
                if (aborted) res_abort_at = c;
                if (ring_en) begin
                    res_ren_cnt++;
                    if (res_ren_first < 0) res_ren_first = c;
                end
                if (res_done_at >= 0 || res_abort_at >= 0) break;
            end
            start  = (c == 0) || hold_start;
            active = (c != abort_at);
            if (c == 0) begin
                a_operand = a; b_operand = b; ring_bit_sel = rs; out_bit_sel = os;
                window_cycles = win;
            end
            if (c == 2) begin
                a_operand = $urandom; b_operand = $urandom;
                ring_bit_sel = 5'($urandom); out_bit_sel = 5'($urandom);
            end
            if (c == 2 + S) window_cycles = 16'($urandom);
            lvl_prev = chain_in;
            if (rnd) begin
                if ($urandom_range(0, 1) == 1) chain_in = ~chain_in;
            end else if (half > 0 && ring_en) begin
                if ((ring_r + 1) % half == 0) chain_in = ~chain_in;
                ring_r++;
            end
            // A rise sampled at the end of cycle c is seen SS cycles later and
            // counts only while the sequencer is in RUN or DRAIN.
            if (chain_in && !lvl_prev && (c + SS >= 2 + S) && (c + SS <= 2 + S + int'(win) + SS)
                && (abort_at < 0 || c + SS <= abort_at))
                res_model_n++;
        end
        active = 1'b1;
        start  = hold_start;
    endtask

    typedef struct {
        logic [31:0] a, b;
        logic [4:0]  rs, os;
        logic [15:0] win;
        int          half;
        logic [31:0] exp_rmask, exp_omask;
        int          exp_done;
        int          exp_cnt;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] one;
        int          exp_sat;
        one = 32'd1;

        vecs[0] = '{32'h0, 32'h0, 5'd25, 5'd31, 16'd80, 4, 32'h0200_0000, 32'h8000_0000, 89, 10};
        vecs[1] = '{32'hFFFF_FFFF, 32'h1, 5'd0, 5'd0, 16'd0, 4, 32'h1, 32'h1, 9, 0};
        vecs[2] = '{32'h1234_5678, 32'h9ABC_DEF0, 5'd7, 5'd7, 16'd12, 4, 32'h80, 32'h80, 21, 2};
        vecs[3] = '{32'hDEAD_BEEF, 32'h0F0F_0F0F, 5'd31, 5'd16, 16'd1, 4, 32'h8000_0000, 32'h0001_0000, 10, 0};
        vecs[4] = '{32'h5, 32'h7, 5'd3, 5'd12, 16'd40, 1, 32'h8, 32'h1000, 49, 20};
        vecs[5] = '{32'hCAFE_F00D, 32'h3, 5'd16, 5'd1, 16'd5, 2, 32'h0001_0000, 32'h2, 14, 1};

        rst = 1'b1; active = 1'b1; start = 1'b0; chain_in = 1'b0;
        window_cycles = 16'hFFFF; a_operand = '1; b_operand = '1;
        ring_bit_sel = 5'd9; out_bit_sel = 5'd9;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < 6; i++) begin
            chain_in = 1'b0;
            idle(4);
            do_run(vecs[i].half, 1'b0, vecs[i].a, vecs[i].b, vecs[i].rs, vecs[i].os,
                   vecs[i].win, -1, 1'b0);
            exp_sat = (vecs[i].exp_cnt > 15) ? 15 : vecs[i].exp_cnt;
            chk($sformatf("v%0d done_latency", i), res_done_at, vecs[i].exp_done);
            chk($sformatf("v%0d ring_en_cycles", i), res_ren_cnt, vecs[i].win);
            if (vecs[i].win != 0) chk($sformatf("v%0d ring_en_first", i), res_ren_first, 2 + S);
            chk($sformatf("v%0d a_input", i), a_input, vecs[i].a);
            chk($sformatf("v%0d b_input", i), b_input, vecs[i].b);
            chk($sformatf("v%0d ring_mask", i), ring_mask, vecs[i].exp_rmask);
            chk($sformatf("v%0d out_mask", i), out_mask, vecs[i].exp_omask);
            chk($sformatf("v%0d count", i), count, vecs[i].exp_cnt);
            chk($sformatf("v%0d overflow", i), overflow, 0);
            chk($sformatf("v%0d count_sat", i), count_s, exp_sat);
            chk($sformatf("v%0d overflow_sat", i), overflow_s, vecs[i].exp_cnt > 15);
            chk($sformatf("v%0d busy_at_done", i), busy, 1);
            @(negedge clk);
            chk($sformatf("v%0d busy_after", i), busy, 0);
            chk($sformatf("v%0d done_pulse", i), done, 0);
            chk($sformatf("v%0d count_hold", i), count, vecs[i].exp_cnt);
            chk($sformatf("v%0d overflow_sat_hold", i), overflow_s, vecs[i].exp_cnt > 15);
        end

        // Abort on RUN cycle 30 (offset 36).
        chain_in = 1'b0;
        idle(4);
        do_run(4, 1'b0, 32'h1, 32'h2, 5'd4, 5'd5, 16'd80, 36, 1'b0);
        chk("abort pulse_at", res_abort_at, 37);
        chk("abort no_done", res_done_at, -1);
        chk("abort ring_en_cycles", res_ren_cnt, 31);
        chk("abort ring_en_after", ring_en, 0);
        chk("abort busy", busy, 0);
        chk("abort partial_count", count, 4);
        @(negedge clk);
        chk("abort pulse_width", aborted, 0);
        chk("abort count_hold", count, 4);

        // active low in IDLE: start is refused and no abort pulse.
        active = 1'b0; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("inactive busy", busy, 0);
            chk("inactive aborted", aborted, 0);
        end
        active = 1'b1; start = 1'b0;
        idle(2);

        // start held high: exactly one run per IDLE visit.
        do_run(4, 1'b0, 32'h11, 32'h22, 5'd1, 5'd2, 16'd10, -1, 1'b1);
        chk("held run1 done", res_done_at, 19);
        do_run(4, 1'b0, 32'h33, 32'h44, 5'd3, 5'd4, 16'd10, -1, 1'b1);
        chk("held run2 idle_gap", res_busy0, 0);
        chk("held run2 done", res_done_at, 19);
        chk("held run2 a_input", a_input, 32'h33);
        start = 1'b0;
        idle(3);

        // Reset in the middle of a run.
        a_operand = 32'hA5A5_A5A5; window_cycles = 16'd50; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idle(20);
        chk("midrst busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("midrst");
        rst = 1'b0;
        idle(2);

        for (int it = 0; it < 14; it++) begin
            logic [31:0] ra, rb;
            logic [4:0]  rrs, ros;
            logic [15:0] rw;
            int          ab;
            ra = $urandom; rb = $urandom;
            rrs = 5'($urandom); ros = 5'($urandom);
            rw = 16'($urandom_range(0, 60));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4 + S + int'(rw))) : -1;
            idle(3);
            do_run(0, 1'b1, ra, rb, rrs, ros, rw, ab, 1'b0);
            exp_sat = (res_model_n > 15) ? 15 : res_model_n;
            if (ab < 0) begin
                chk($sformatf("rnd%0d done_latency", it), res_done_at, 5 + S + int'(rw));
                chk($sformatf("rnd%0d ring_en_cycles", it), res_ren_cnt, rw);
                chk($sformatf("rnd%0d a_input", it), a_input, ra);
                chk($sformatf("rnd%0d b_input", it), b_input, rb);
                chk($sformatf("rnd%0d ring_mask", it), ring_mask, one << rrs);
                chk($sformatf("rnd%0d out_mask", it), out_mask, one << ros);
            end else begin
                chk($sformatf("rnd%0d abort_at", it), res_abort_at, ab + 1);
                chk($sformatf("rnd%0d abort_no_done", it), res_done_at, -1);
                chk($sformatf("rnd%0d abort_busy", it), busy, 0);
            end
            chk($sformatf("rnd%0d count", it), count, res_model_n);
            chk($sformatf("rnd%0d count_sat", it), count_s, exp_sat);
            chk($sformatf("rnd%0d overflow_sat", it), overflow_s, res_model_n > 15);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
